// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer: register map,
// CTRL field layout, mode codes and FSM state encodings.
package timer_counter_pkg;

    localparam logic [31:0] TC_BASE_ADDR = 32'h0000_7F00;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PRESET = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int CTRL_W        = 4;
    localparam int CTRL_EN       = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_IM       = 3;

    localparam logic [1:0] MODE_ONESHOT  = 2'd0;
    localparam logic [1:0] MODE_PERIODIC = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Only MODE 1 reloads; codes 2 and 3 behave as one-shot.
    function automatic logic is_periodic(input logic [CTRL_W-1:0] ctrl);
        return ctrl[CTRL_MODE_LSB +: 2] == MODE_PERIODIC;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Down-counting timer with CTRL/PRESET/COUNT registers on the system bridge;
// IRQ is the masked interrupt flag and drives HWInt[0].
module timer_counter
    import timer_counter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [CTRL_W-1:0] ctrl_q;
    logic [CNT_W-1:0]  preset_q;
    logic [CNT_W-1:0]  count_q;
    logic              irq_flag_q;
    tc_state_e         state_q;

    logic wr_ctrl;
    logic wr_preset;
    logic unused_addr;

    assign wr_ctrl     = WE && (Addr[3:2] == REG_CTRL);
    assign wr_preset   = WE && (Addr[3:2] == REG_PRESET);
    assign unused_addr = ^Addr[31:4];

    always_ff @(posedge clk) begin
        if (!rst) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
            state_q    <= ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ctrl_q[CTRL_EN]) state_q <= ST_LOAD;
                end
                ST_LOAD: begin
                    count_q    <= preset_q;
                    irq_flag_q <= 1'b0;
                    state_q    <= ST_CNT;
                end
                ST_CNT: begin
                    if (!ctrl_q[CTRL_EN]) begin
                        state_q <= ST_IDLE;
                    end else if (count_q > CNT_W'(1)) begin
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        count_q <= '0;
                        state_q <= ST_INT;
                    end
                end
                ST_INT: begin
                    irq_flag_q <= 1'b1;
                    if (is_periodic(ctrl_q)) begin
                        state_q <= ctrl_q[CTRL_EN] ? ST_LOAD : ST_IDLE;
                    end else begin
                        ctrl_q[CTRL_EN] <= 1'b0;
                        state_q         <= ST_IDLE;
                    end
                end
            endcase

            // Bus writes come last so a CTRL store overrides the FSM's EN clear
            // and flag set in the same cycle.
            if (wr_preset) preset_q <= Din[CNT_W-1:0];
            if (wr_ctrl) begin
                ctrl_q     <= Din[CTRL_W-1:0];
                irq_flag_q <= 1'b0;
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            REG_CTRL:   Dout = 32'(ctrl_q);
            REG_PRESET: Dout = 32'(preset_q);
            REG_COUNT:  Dout = 32'(count_q);
            default:    Dout = '0;
        endcase
    end

    assign IRQ = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: a run-timeline reference model compared every cycle,
// plus directed register-level scenarios with hand-derived expectations.
module tb_timer_counter;

    logic        clk;
    logic        rst;
    logic [31:2] addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    timer_counter #(.CNT_W(32)) dut (
        .clk  (clk),
        .rst  (rst),
        .Addr (addr),
        .WE   (we),
        .Din  (din),
        .Dout (dout),
        .IRQ  (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a run is a timeline measured in edges since the timer
    // left idle. Edge 1 enters the load slot, edge 2 copies PRESET, the next
    // max(PRESET,1) edges count down, and the edge after that raises the flag.
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_flag;
    int          m_ph;
    longint      m_len;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_ctrl   = 4'd0;
            m_preset = 32'd0;
            m_count  = 32'd0;
            m_flag   = 1'b0;
            m_ph     = 0;
            m_len    = 1;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            if (m_ph == 0) begin
                if (m_ctrl[0]) m_ph = 1;
            end else if (m_ph == 1) begin
                m_count = m_preset;
                m_len   = (m_preset == 32'd0) ? 1 : longint'(m_preset);
                m_flag  = 1'b0;
                m_ph    = 2;
            end else if (longint'(m_ph) < 2 + m_len) begin
                if (!m_ctrl[0]) begin
                    m_ph = 0;
                end else begin
                    m_count = (longint'(m_ph) == 1 + m_len) ? 32'd0 : m_count - 32'd1;
                    m_ph++;
                end
            end else begin
                m_flag = 1'b1;
                if (m_ctrl[2:1] == 2'd1) begin
                    m_ph = m_ctrl[0] ? 1 : 0;
                end else begin
                    m_ctrl[0] = 1'b0;
                    m_ph      = 0;
                end
            end
            if (we && addr[3:2] == 2'd1) m_preset = din;
            if (we && addr[3:2] == 2'd0) begin
                m_ctrl = din[3:0];
                m_flag = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            logic [31:0] exp_dout;
            case (addr[3:2])
                2'd0:    exp_dout = {28'd0, m_ctrl};
                2'd1:    exp_dout = m_preset;
                2'd2:    exp_dout = m_count;
                default: exp_dout = 32'd0;
            endcase
            check("model_dout", dout, exp_dout);
            check("model_irq", {31'd0, irq}, {31'd0, m_ctrl[3] & m_flag});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        addr = {28'd0, a};
        din  = d;
        we   = 1'b1;
        step(1);
        we   = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [1:0] a, input logic [31:0] exp);
        addr = {28'd0, a};
        #1;
        check(nm, dout, exp);
    endtask

    task automatic irq_chk(input string nm, input logic exp);
        check(nm, {31'd0, irq}, {31'd0, exp});
    endtask

    // Disable and let any in-flight load/count/int sequence drain back to idle.
    task automatic stop();
        wr(2'd0, 32'h0);
        step(4);
    endtask

    initial begin
        rst  = 1'b0;
        we   = 1'b0;
        addr = '0;
        din  = '0;

        // Reset held two cycles
        step(2);
        rd_chk("rst_ctrl", 2'd0, 32'd0);
        rd_chk("rst_preset", 2'd1, 32'd0);
        rd_chk("rst_count", 2'd2, 32'd0);
        irq_chk("rst_irq", 1'b0);
        rst = 1'b1;
        step(1);

        // One-shot, PRESET=5: flag rises on the 8th edge after the enabling write
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        addr = {28'd0, 2'd2};
        step(1);
        for (int v = 5; v >= 1; v--) begin
            step(1);
            rd_chk("os_count", 2'd2, 32'(v));
            irq_chk("os_irq_low", 1'b0);
        end
        step(1);
        rd_chk("os_count0", 2'd2, 32'd0);
        irq_chk("os_irq_pre", 1'b0);
        step(1);
        irq_chk("os_irq_rise", 1'b1);
        rd_chk("os_ctrl_en_cleared", 2'd0, 32'h8);
        step(3);
        irq_chk("os_irq_sticky", 1'b1);
        wr(2'd0, 32'h8);
        irq_chk("os_irq_cleared", 1'b0);
        stop();

        // Periodic, PRESET=3: one-cycle pulses every 5 cycles
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        addr = {28'd0, 2'd2};
        step(5);
        irq_chk("per_irq_pre", 1'b0);
        for (int p = 0; p < 4; p++) begin
            step(1);
            irq_chk("per_pulse", 1'b1);
            step(1);
            irq_chk("per_pulse_end", 1'b0);
            step(3);
            irq_chk("per_gap", 1'b0);
        end
        stop();

        // PRESET rewritten mid-count: current run unaffected, next load sees 7
        wr(2'd0, 32'hB);
        step(2);
        rd_chk("pw_load", 2'd2, 32'd3);
        wr(2'd1, 32'd7);
        rd_chk("pw_count", 2'd2, 32'd2);
        step(3);
        irq_chk("pw_irq", 1'b1);
        step(1);
        rd_chk("pw_reload", 2'd2, 32'd7);
        irq_chk("pw_irq_end", 1'b0);
        stop();

        // Masked periodic never raises IRQ
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h3);
        addr = {28'd0, 2'd2};
        step(12);
        irq_chk("mask_irq", 1'b0);
        stop();

        // Clearing EN mid-count freezes COUNT
        wr(2'd0, 32'h3);
        step(2);
        rd_chk("frz_load", 2'd2, 32'd2);
        wr(2'd0, 32'h2);
        rd_chk("frz_count", 2'd2, 32'd1);
        step(3);
        rd_chk("frz_hold", 2'd2, 32'd1);
        irq_chk("frz_irq", 1'b0);

        // COUNT is read-only
        wr(2'd2, 32'h55);
        rd_chk("cnt_ro", 2'd2, 32'd1);
        rd_chk("ctrl_rb", 2'd0, 32'h2);
        rd_chk("preset_rb", 2'd1, 32'd2);
        rd_chk("addr3_zero", 2'd3, 32'd0);
        stop();

        // PRESET=0 still spends one count cycle: IRQ after 4 edges
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        step(3);
        irq_chk("p0_irq_pre", 1'b0);
        step(1);
        irq_chk("p0_irq", 1'b1);
        rd_chk("p0_count", 2'd2, 32'd0);
        stop();

        // CTRL write landing on the INT edge keeps the written EN and clears the flag
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h9);
        step(3);
        wr(2'd0, 32'h9);
        rd_chk("col_ctrl", 2'd0, 32'h9);
        irq_chk("col_irq", 1'b0);
        step(3);
        irq_chk("col_rerun_pre", 1'b0);
        step(1);
        irq_chk("col_rerun_irq", 1'b1);
        rd_chk("col_ctrl_after", 2'd0, 32'h8);
        stop();

        // Reset in mid-count
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        step(4);
        rd_chk("mid_count", 2'd2, 32'd3);
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        rd_chk("mid_rst_ctrl", 2'd0, 32'd0);
        rd_chk("mid_rst_preset", 2'd1, 32'd0);
        rd_chk("mid_rst_count", 2'd2, 32'd0);
        irq_chk("mid_rst_irq", 1'b0);
        step(10);
        irq_chk("mid_post_irq", 1'b0);
        rd_chk("mid_post_count", 2'd2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
